dcache_writeback_buffer: RTL
============================

# dcache_writeback_buffer

Block-writeback buffer between the data cache and the data-side memory port (dBlkRead/dBlkWrite, 256-bit blocks). It queues evicted dirty blocks so the cache can refill without first waiting for the eviction to finish. It arbitrates the single memory address bus between cache refill reads and buffered writebacks. It also enforces read-after-write ordering for blocks that are still buffered.

## Interface
Parameters:
- DEPTH, 4: number of 256-bit entries (power of two, 2..8).

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-low reset.
- wb_valid  in  1  cache presents an evicted dirty block.
- wb_addr  in  27  block address, bits [31:5].
- wb_block  in  256  block data.
- wb_ready  out  1  buffer can accept; push = wb_valid && wb_ready.
- rd_req  in  1  cache refill request; held until rd_valid.
- rd_addr  in  27  refill block address [31:5].
- rd_block  out  256  refill data.
- rd_valid  out  1  one-cycle pulse; rd_block valid.
- flush  in  1  drain request (syscall path).
- drained  out  1  buffer is empty and FSM is IDLE.
- mem_addr  out  32  {block addr, 5'b0} to memory.
- mem_blk_read  out  1  maps to dBlkRead.
- mem_blk_write  out  1  maps to dBlkWrite.
- mem_wblock  out  256  write data (head entry).
- mem_rblock  in  256  block_read_fDM.
- mem_read_valid  in  1  block_read_fDM_valid.
- mem_write_valid  in  1  block_write_fDM_valid.

## Operation
- Storage is a circular FIFO with head/tail pointers of width log2(DEPTH) that wrap modulo DEPTH, plus a count of width log2(DEPTH)+1. Each entry holds an addr, a block and a valid bit.
- wb_ready = (count < DEPTH) || coalesce_hit. It does not depend on a same-cycle pop.
- Coalescing:
  - A push whose wb_addr matches a valid non-head entry overwrites that entry's block. Count is unchanged.
  - A push that matches the head allocates a new tail entry, because the head may already be in flight.
- Hit detection: rd_addr is compared against all valid entries. The youngest match wins.
- FSM states:
  - IDLE, with priority:
    - (a) rd_req && hit: go to FWD.
    - (b) rd_req && !hit: go to READ.
    - (c) count>0 and (flush or no rd_req): go to WRITE.
  - READ: mem_blk_read=1, mem_addr=rd_addr. On mem_read_valid, latch mem_rblock into rd_block, pulse rd_valid, and go to IDLE.
  - WRITE: mem_blk_write=1, mem_addr=head addr, mem_wblock=head block. On mem_write_valid, pop the head and go to IDLE.
  - FWD: behaviour depends on WB_READ_FORWARD_EN (see Configuration).
- Push, pop and coalesce can happen in the same cycle. The count update is (push_new ? +1 : 0) − (pop ? 1 : 0).
- drained = (count==0) && state==IDLE.
- flush only raises write priority. It does not block pushes.

## Timing
- Reset (RESET=0 at an edge):
  - state=IDLE, head=tail=count=0, all valid bits=0.
  - rd_valid=0, rd_block=0, mem_blk_read=0, mem_blk_write=0, mem_addr=0, mem_wblock=0.
  - wb_ready=1, drained=1.
  - Reset mid-transaction aborts it; no partial pop occurs.
- mem_* outputs are registered by state: asserted the cycle after the IDLE decision and held until the memory valid arrives.
- A read miss with no write in flight has latency = memory latency + 2 cycles (IDLE decision, then READ state; rd_valid follows the valid).
- A read that arrives while a WRITE is in flight waits for that write to complete. A write is never abandoned.
- A forwarded hit gives rd_valid exactly 2 cycles after rd_req rises in IDLE.
- A push into a full, non-coalescing buffer is refused (wb_ready=0). It is accepted on the first cycle after a pop.

## Configuration
- WB_READ_FORWARD_EN defined:
  - FWD returns the youngest matching entry's block on rd_block and pulses rd_valid for one cycle.
  - The entry is not popped.
  - Memory is not accessed.
- WB_READ_FORWARD_EN undefined:
  - A hit routes the FSM to WRITE repeatedly until no matching entry remains, then to READ.
  - FWD is unreachable.
  - rd_valid only ever carries memory data.

## Test plan
- Reset, then three pushes to addrs 0x10, 0x20, 0x30 with no reads. Required: three WRITE transactions in FIFO order, with mem_addr 0x200, 0x400, 0x600. drained=1 after the third mem_write_valid.
- DEPTH=4, four distinct pushes, memory withholding mem_write_valid. Required: wb_ready=0. A fifth push is held off until one cycle after the first mem_write_valid.
- Push 0x20 with data A, push 0x30, then push 0x30 with data B. Required: count stays 2, and the write to 0x600 carries B.
- Refill rd_addr=0x20 while 0x20 is buffered with data A.
  - WB_READ_FORWARD_EN defined: rd_valid=1 with rd_block=A after 2 cycles, and no mem_blk_read.
  - WB_READ_FORWARD_EN undefined: the 0x20 write completes before mem_blk_read is asserted.
- Refill miss 0x99 while the buffer holds 2 entries. Required: READ is issued before any WRITE. rd_block equals mem_rblock, and rd_valid pulses for exactly 1 cycle.
- RESET=0 during WRITE, with mem_write_valid arriving in the same cycle. Required: on the next cycle count=0 and mem_blk_write=0. No entry survives.

Source files
------------

// File: rtl/dcache_writeback_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dcache_writeback_buffer
// Purpose  : Dirty-block writeback FIFO with refill/writeback arbitration and
//            read-after-write ordering. Optional macro WB_READ_FORWARD_EN
//            serves refill hits straight from the buffer.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         wb_valid,
    input  logic [26:0]  wb_addr,
    input  logic [255:0] wb_block,
    output logic         wb_ready,
    input  logic         rd_req,
    input  logic [26:0]  rd_addr,
    output logic [255:0] rd_block,
    output logic         rd_valid,
    input  logic         flush,
    output logic         drained,
    output logic [31:0]  mem_addr,
    output logic         mem_blk_read,
    output logic         mem_blk_write,
    output logic [255:0] mem_wblock,
    input  logic [255:0] mem_rblock,
    input  logic         mem_read_valid,
    input  logic         mem_write_valid
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] FWD   = 2'd3;

    logic [26:0]      ent_addr  [DEPTH];
    logic [255:0]     ent_block [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PTR_W-1:0] head, tail, scan_idx;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;

    logic [DEPTH-1:0] coal_mask;
    logic coalesce_hit, push, push_new, pop, rd_hit;
    logic go_fwd, go_read, go_write;
`ifdef WB_READ_FORWARD_EN
    logic [PTR_W-1:0] hit_idx;
`endif

    // The head is never coalesced into: it may already be on the memory bus.
    always_comb begin
        coal_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && ent_addr[i] == wb_addr && PTR_W'(i) != head)
                coal_mask[i] = 1'b1;
        end
    end

    assign coalesce_hit = |coal_mask;
    assign wb_ready     = (count < CNT_W'(DEPTH)) || coalesce_hit;
    assign push         = wb_valid && wb_ready;
    assign push_new     = push && !coalesce_hit;
    assign pop          = (state == WRITE) && mem_write_valid;
    assign drained      = (count == '0) && (state == IDLE);

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        rd_hit   = 1'b0;
        scan_idx = '0;
`ifdef WB_READ_FORWARD_EN
        hit_idx  = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head + PTR_W'(k);
            if (ent_valid[scan_idx] && ent_addr[scan_idx] == rd_addr) begin
                rd_hit = 1'b1;
`ifdef WB_READ_FORWARD_EN
                hit_idx = scan_idx;
`endif
            end
        end
    end

    always_comb begin
        go_fwd   = 1'b0;
        go_read  = 1'b0;
        go_write = 1'b0;
        if (rd_req && rd_hit) begin
`ifdef WB_READ_FORWARD_EN
            go_fwd = 1'b1;
`else
            go_write = 1'b1;
`endif
        end else if (rd_req) begin
            go_read = 1'b1;
        end else if (count != '0 && (flush || !rd_req)) begin
            go_write = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && coal_mask[i])
                ent_block[i] <= wb_block;
        end
        if (push_new) begin
            ent_addr[tail]  <= wb_addr;
            ent_block[tail] <= wb_block;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state         <= IDLE;
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ent_valid     <= '0;
            rd_valid      <= 1'b0;
            rd_block      <= '0;
            mem_blk_read  <= 1'b0;
            mem_blk_write <= 1'b0;
            mem_addr      <= '0;
            mem_wblock    <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (push_new) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            count <= count + CNT_W'(push_new) - CNT_W'(pop);

            case (state)
                IDLE: begin
                    if (go_fwd) begin
                        state <= FWD;
                    end else if (go_write) begin
                        state         <= WRITE;
                        mem_blk_write <= 1'b1;
                        mem_addr      <= {ent_addr[head], 5'b0};
                        mem_wblock    <= ent_block[head];
                    end else if (go_read) begin
                        state        <= READ;
                        mem_blk_read <= 1'b1;
                        mem_addr     <= {rd_addr, 5'b0};
                    end
                end
                READ: begin
                    if (mem_read_valid) begin
                        rd_block     <= mem_rblock;
                        rd_valid     <= 1'b1;
                        mem_blk_read <= 1'b0;
                        state        <= IDLE;
                    end
                end
                WRITE: begin
                    if (mem_write_valid) begin
                        mem_blk_write <= 1'b0;
                        state         <= IDLE;
                    end
                end
                FWD: begin
`ifdef WB_READ_FORWARD_EN
                    rd_block <= ent_block[hit_idx];
                    rd_valid <= 1'b1;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
